// File: rtl/arb_pkg.sv
// arb_pkg: shared arbiter constants, state encoding and rotate/encode helpers
package arb_pkg;
  localparam int ARB_N     = 8;
  localparam int ARB_IDX_W = 3;

  typedef enum logic {ST_IDLE, ST_GRANT} arb_state_e;

  function automatic logic [ARB_N-1:0] rotr8(input logic [ARB_N-1:0] m, input logic [ARB_IDX_W-1:0] s);
    logic [2*ARB_N-1:0] t;
    t = {m, m} >> s;
    return t[ARB_N-1:0];
  endfunction

  function automatic logic [ARB_N-1:0] rotl8(input logic [ARB_N-1:0] m, input logic [ARB_IDX_W-1:0] s);
    logic [2*ARB_N-1:0] t;
    t = {m, m} << s;
    return t[2*ARB_N-1:ARB_N];
  endfunction

  function automatic logic [ARB_IDX_W-1:0] pri_enc8(input logic [ARB_N-1:0] m);
    logic [ARB_IDX_W-1:0] e;
    e = '0;
    for (int i = ARB_N - 1; i >= 0; i--) if (m[i]) e = ARB_IDX_W'(i);
    return e;
  endfunction
endpackage

// File: rtl/rr_pick8.sv
// rr_pick8: circular first-set-bit search starting at base
module rr_pick8
  import arb_pkg::*;
(
  input  logic [ARB_N-1:0]     mask,
  input  logic [ARB_IDX_W-1:0] base,
  output logic [ARB_IDX_W-1:0] idx,
  output logic                 any
);
  logic [ARB_N-1:0] rot;
  // rotate so base sits at bit 0, take the lowest set bit, then undo the rotation
  always_comb begin
    rot = rotr8(mask, base);
    idx = pri_enc8(rot) + base;
    any = |mask;
  end
endmodule

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: eight-way round-robin arbiter with grant hold and starvation timeout
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int N        = 8,
  parameter int IDX_W    = 3,
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);
  arb_state_e        state_q, state_d;
  logic [N-1:0]      gnt_q, gnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d, ptr_q, ptr_d, nxt, pick_base, pick_idx;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              timeout_q, timeout_d, rel_vol, rel_frc, pick_any;
  logic [N-1:0]      pick_mask;

  assign nxt       = idx_q + 1'b1;
  assign rel_vol   = (state_q == ST_GRANT) && !req[idx_q];
  assign rel_frc   = (state_q == ST_GRANT) && req[idx_q] && (MAX_HOLD != 0) && (hold_q == HOLD_W'(MAX_HOLD - 1));
  // a forced release keeps the holder as a candidate; starting just past it puts it last
  assign pick_mask = (state_q == ST_IDLE) ? req : rel_vol ? (req & ~(N'(1) << idx_q)) : req;
  assign pick_base = (state_q == ST_IDLE) ? ptr_q : nxt;

  rr_pick8 u_pick (
    .mask (pick_mask),
    .base (pick_base),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // next-state: arbitrate when idle or when the current grant ends, otherwise keep holding
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    if (state_q == ST_IDLE || rel_vol || rel_frc) begin
      if (state_q == ST_GRANT) ptr_d = nxt;
      timeout_d = rel_frc;
      hold_d    = '0;
      state_d   = pick_any ? ST_GRANT : ST_IDLE;
      gnt_d     = pick_any ? N'(1) << pick_idx : '0;
      idx_d     = pick_any ? pick_idx : idx_q;
    end else begin
      hold_d = (hold_q != '1) ? hold_q + 1'b1 : hold_q;
    end
  end

  // state and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      idx_q     <= '0;
      ptr_q     <= '0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = |gnt_q;
  assign timeout   = timeout_q;
endmodule
